// File: rtl/kp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | kp_pkg : shared types and MIDI constants for the Karplus-Strong      |
// |          note-control slice                                          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package kp_pkg;

  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_D1   = 2'd1,
    P_D2   = 2'd2
  } parse_state_t;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_LOAD = 2'd1,
    T_HOLD = 2'd2,
    T_GAP  = 2'd3
  } trig_state_t;

  typedef logic [11:0] delay_len_t;

  localparam logic [7:0] KP_MIDI_NOTE_ON    = 8'h90;
  localparam logic [7:0] KP_MIDI_SYS_COMMON = 8'hF0;
  localparam logic [7:0] KP_MIDI_REALTIME   = 8'hF8;

  localparam logic [6:0] KP_NOTE_LO = 7'd21;
  localparam logic [6:0] KP_NOTE_HI = 7'd108;

endpackage

`default_nettype wire

// File: rtl/kp_note_rom.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | kp_note_rom : 88 x 12 synchronous pitch table, round(96000 / f(n)),   |
// |               addressed by (note - 21), one cycle read latency        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module kp_note_rom
  import kp_pkg::*;
(
  input  logic       m_clk,
  input  logic [6:0] i_addr,
  output delay_len_t o_data
);

  delay_len_t w_data;
  delay_len_t r_data;

  // One octave per row group: each row of twelve halves the length of the one above
  always_comb begin
    w_data = '0;
    case (i_addr)
      7'd0:  w_data = 12'd3491;
      7'd1:  w_data = 12'd3295; 7'd2:  w_data = 12'd3110; 7'd3:  w_data = 12'd2935; 7'd4:  w_data = 12'd2771;
      7'd5:  w_data = 12'd2615; 7'd6:  w_data = 12'd2468; 7'd7:  w_data = 12'd2330; 7'd8:  w_data = 12'd2199;
      7'd9:  w_data = 12'd2076; 7'd10: w_data = 12'd1959; 7'd11: w_data = 12'd1849; 7'd12: w_data = 12'd1745;
      7'd13: w_data = 12'd1647; 7'd14: w_data = 12'd1555; 7'd15: w_data = 12'd1468; 7'd16: w_data = 12'd1385;
      7'd17: w_data = 12'd1308; 7'd18: w_data = 12'd1234; 7'd19: w_data = 12'd1165; 7'd20: w_data = 12'd1100;
      7'd21: w_data = 12'd1038; 7'd22: w_data = 12'd980;  7'd23: w_data = 12'd925;  7'd24: w_data = 12'd873;
      7'd25: w_data = 12'd824;  7'd26: w_data = 12'd778;  7'd27: w_data = 12'd734;  7'd28: w_data = 12'd693;
      7'd29: w_data = 12'd654;  7'd30: w_data = 12'd617;  7'd31: w_data = 12'd582;  7'd32: w_data = 12'd550;
      7'd33: w_data = 12'd519;  7'd34: w_data = 12'd490;  7'd35: w_data = 12'd462;  7'd36: w_data = 12'd436;
      7'd37: w_data = 12'd412;  7'd38: w_data = 12'd389;  7'd39: w_data = 12'd367;  7'd40: w_data = 12'd346;
      7'd41: w_data = 12'd327;  7'd42: w_data = 12'd309;  7'd43: w_data = 12'd291;  7'd44: w_data = 12'd275;
      7'd45: w_data = 12'd259;  7'd46: w_data = 12'd245;  7'd47: w_data = 12'd231;  7'd48: w_data = 12'd218;
      7'd49: w_data = 12'd206;  7'd50: w_data = 12'd194;  7'd51: w_data = 12'd183;  7'd52: w_data = 12'd173;
      7'd53: w_data = 12'd163;  7'd54: w_data = 12'd154;  7'd55: w_data = 12'd146;  7'd56: w_data = 12'd137;
      7'd57: w_data = 12'd130;  7'd58: w_data = 12'd122;  7'd59: w_data = 12'd116;  7'd60: w_data = 12'd109;
      7'd61: w_data = 12'd103;  7'd62: w_data = 12'd97;   7'd63: w_data = 12'd92;   7'd64: w_data = 12'd87;
      7'd65: w_data = 12'd82;   7'd66: w_data = 12'd77;   7'd67: w_data = 12'd73;   7'd68: w_data = 12'd69;
      7'd69: w_data = 12'd65;   7'd70: w_data = 12'd61;   7'd71: w_data = 12'd58;   7'd72: w_data = 12'd55;
      7'd73: w_data = 12'd51;   7'd74: w_data = 12'd49;   7'd75: w_data = 12'd46;   7'd76: w_data = 12'd43;
      7'd77: w_data = 12'd41;   7'd78: w_data = 12'd39;   7'd79: w_data = 12'd36;   7'd80: w_data = 12'd34;
      7'd81: w_data = 12'd32;   7'd82: w_data = 12'd31;   7'd83: w_data = 12'd29;   7'd84: w_data = 12'd27;
      7'd85: w_data = 12'd26;   7'd86: w_data = 12'd24;   7'd87: w_data = 12'd23;
      default: w_data = '0;
    endcase
  end

  always_ff @(posedge m_clk) begin
    r_data <= w_data;
  end

  assign o_data = r_data;

endmodule

`default_nettype wire

// File: rtl/kp_midi_note_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | kp_midi_note_ctrl : MIDI note-on parser and held trigger generator    |
// |   for the Karplus-Strong voice. Define KP_VEL_CURVE_EN for the        |
// |   squared velocity curve; linear velocity otherwise.                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module kp_midi_note_ctrl
  import kp_pkg::*;
#(
  parameter int unsigned MIDI_CH   = 0,
  parameter int unsigned TRIG_HOLD = 32768,
  parameter int unsigned TRIG_GAP  = 32768
) (
  input  logic       m_clk,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       trig,
  output logic [6:0] velocity,
  output delay_len_t delay_length,
  output logic [6:0] note,
  output logic       busy
);

  localparam logic [7:0]  c_note_on_ch = KP_MIDI_NOTE_ON | {4'h0, MIDI_CH[3:0]};
  localparam logic [15:0] c_hold_rld   = 16'(TRIG_HOLD - 1);
  localparam logic [15:0] c_gap_rld    = 16'(TRIG_GAP - 1);

  // ---------------- parser ----------------
  parse_state_t r_p_state, w_p_next;
  logic [6:0]   r_note_rx;
  logic         w_is_data, w_vel_evt, w_in_range;

  assign w_is_data  = rx_valid && !rx_data[7];
  assign w_vel_evt  = w_is_data && (r_p_state == P_D2);
  assign w_in_range = (r_note_rx >= KP_NOTE_LO) && (r_note_rx <= KP_NOTE_HI);

  // P_D1/P_D2 double as the running-status flag: only note-on status leaves P_IDLE
  always_comb begin
    w_p_next = r_p_state;
    if (rx_valid) begin
      if (rx_data >= KP_MIDI_REALTIME)        w_p_next = r_p_state;
      else if (rx_data >= KP_MIDI_SYS_COMMON) w_p_next = P_IDLE;
      else if (rx_data == c_note_on_ch)       w_p_next = P_D1;
      else if (rx_data[7])                    w_p_next = P_IDLE;
      else begin
        case (r_p_state)
          P_D1:    w_p_next = P_D2;
          P_D2:    w_p_next = P_D1;
          default: w_p_next = P_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge m_clk) begin
    if (!reset_n) begin
      r_p_state <= P_IDLE;
      r_note_rx <= '0;
    end else begin
      r_p_state <= w_p_next;
      if (w_is_data && (r_p_state == P_D1)) r_note_rx <= rx_data[6:0];
    end
  end

  // ---------------- candidate stage (ROM read cycle) ----------------
  delay_len_t w_rom_data;
  logic       r_cand_vld;
  logic [6:0] r_cand_note, r_cand_vel;

  kp_note_rom u_rom (
    .m_clk  (m_clk),
    .i_addr (r_note_rx - KP_NOTE_LO),
    .o_data (w_rom_data)
  );

  always_ff @(posedge m_clk) begin
    if (!reset_n) begin
      r_cand_vld  <= 1'b0;
      r_cand_note <= '0;
      r_cand_vel  <= '0;
    end else begin
      r_cand_vld <= w_vel_evt && (rx_data[6:0] != 7'd0) && w_in_range;
      if (w_vel_evt) begin
        r_cand_note <= r_note_rx;
        r_cand_vel  <= rx_data[6:0];
      end
    end
  end

  // ---------------- trigger FSM ----------------
  trig_state_t r_t_state, w_t_next;
  logic [15:0] r_cnt;
  logic        r_pend_vld;
  logic [6:0]  r_pend_note, r_pend_vel, w_vel_out;
  delay_len_t  r_pend_len;
  logic        r_trig, r_busy;
  logic [6:0]  r_velocity, r_note;
  delay_len_t  r_delay_length;

`ifdef KP_VEL_CURVE_EN
  logic [6:0] w_vel_curve;
  assign w_vel_curve = 7'(({7'd0, r_pend_vel} * {7'd0, r_pend_vel}) >> 7);
  assign w_vel_out   = (w_vel_curve == 7'd0) ? 7'd1 : w_vel_curve;
`else
  assign w_vel_out = r_pend_vel;
`endif

  always_comb begin
    w_t_next = r_t_state;
    case (r_t_state)
      T_IDLE:  if (r_cand_vld || r_pend_vld) w_t_next = T_LOAD;
      T_LOAD:  w_t_next = T_HOLD;
      T_HOLD:  if (r_cnt == 16'd0) w_t_next = T_GAP;
      T_GAP:   if (r_cnt == 16'd0) w_t_next = r_pend_vld ? T_LOAD : T_IDLE;
      default: w_t_next = T_IDLE;
    endcase
  end

  always_ff @(posedge m_clk) begin
    if (!reset_n) begin
      r_t_state <= T_IDLE;
      r_cnt     <= '0;
    end else begin
      r_t_state <= w_t_next;
      if (w_t_next != r_t_state) begin
        case (w_t_next)
          T_HOLD:  r_cnt <= c_hold_rld;
          T_GAP:   r_cnt <= c_gap_rld;
          default: r_cnt <= '0;
        endcase
      end else if (r_cnt != 16'd0) begin
        r_cnt <= r_cnt - 16'd1;
      end
    end
  end

  // Every accepted note lands in the slot; T_LOAD drains it unless a newer one arrives
  always_ff @(posedge m_clk) begin
    if (!reset_n) begin
      r_pend_vld     <= 1'b0;
      r_pend_note    <= '0;
      r_pend_vel     <= '0;
      r_pend_len     <= '0;
      r_trig         <= 1'b1;
      r_busy         <= 1'b0;
      r_velocity     <= '0;
      r_note         <= '0;
      r_delay_length <= '0;
    end else begin
      r_trig <= (r_t_state != T_HOLD);
      r_busy <= (r_t_state == T_HOLD) || (r_t_state == T_GAP);
      if (r_t_state == T_LOAD) begin
        r_note         <= r_pend_note;
        r_velocity     <= w_vel_out;
        r_delay_length <= r_pend_len;
      end
      if (r_cand_vld) begin
        r_pend_vld  <= 1'b1;
        r_pend_note <= r_cand_note;
        r_pend_vel  <= r_cand_vel;
        r_pend_len  <= w_rom_data;
      end else if (r_t_state == T_LOAD) begin
        r_pend_vld <= 1'b0;
      end
    end
  end

  assign trig         = r_trig;
  assign busy         = r_busy;
  assign velocity     = r_velocity;
  assign note         = r_note;
  assign delay_length = r_delay_length;

endmodule

`default_nettype wire

// File: tb/tb_kp_midi_note_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_kp_midi_note_ctrl : directed self-checking bench, HOLD = GAP = 8    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_kp_midi_note_ctrl;

  localparam int unsigned c_hold = 8;
  localparam int unsigned c_gap  = 8;

`ifdef KP_VEL_CURVE_EN
  localparam logic [6:0] c_v100 = 7'd78,  c_v64 = 7'd32, c_v127 = 7'd126, c_v80 = 7'd50;
`else
  localparam logic [6:0] c_v100 = 7'd100, c_v64 = 7'd64, c_v127 = 7'd127, c_v80 = 7'd80;
`endif

  logic        m_clk   = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        trig;
  logic [6:0]  velocity;
  logic [11:0] delay_length;
  logic [6:0]  note;
  logic        busy;

  int n_cmp  = 0;
  int n_err  = 0;
  int n_fall = 0;
  int n_exp  = 0;
  logic prev_trig = 1'b1;

  kp_midi_note_ctrl #(
    .MIDI_CH   (0),
    .TRIG_HOLD (c_hold),
    .TRIG_GAP  (c_gap)
  ) dut (
    .m_clk        (m_clk),
    .reset_n      (reset_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .trig         (trig),
    .velocity     (velocity),
    .delay_length (delay_length),
    .note         (note),
    .busy         (busy)
  );

  always #5 m_clk = ~m_clk;

  always @(negedge m_clk) begin
    if (prev_trig === 1'b1 && trig === 1'b0) n_fall++;
    prev_trig = trig;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge m_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] seq[$]);
    foreach (seq[i]) send_byte(seq[i]);
  endtask

  task automatic wait_trig(input string tag, input logic lvl);
    int n = 0;
    while (trig !== lvl && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_reached"}, 32'(trig), 32'(lvl));
  endtask

  task automatic measure(input logic lvl, output int n);
    n = 0;
    while (trig === lvl && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;

    repeat (3) tick();
    chk("rst_trig",  32'(trig), 32'd1);
    chk("rst_vel",   32'(velocity), 32'd0);
    chk("rst_len",   32'(delay_length), 32'd0);
    chk("rst_note",  32'(note), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    reset_n = 1'b1;
    tick(); tick();

    // basic note-on and latency
    send_seq('{8'h90, 8'h45, 8'h64});
    chk("t1_pre_len", 32'(delay_length), 32'd0);
    tick(); tick();
    chk("t1_len",     32'(delay_length), 32'd218);
    chk("t1_vel",     32'(velocity), 32'(c_v100));
    chk("t1_note",    32'(note), 32'd69);
    chk("t1_trig_hi", 32'(trig), 32'd1);
    chk("t1_busy_lo", 32'(busy), 32'd0);
    tick();
    chk("t1_trig_lo", 32'(trig), 32'd0);
    chk("t1_busy_hi", 32'(busy), 32'd1);
    measure(1'b0, n);
    chk("t1_hold_len", 32'(n), 32'(c_hold));
    wait_idle("t1");
    n_exp = 1;
    chk("t1_count", 32'(n_fall), 32'(n_exp));

    // running status, second note arrives during HOLD
    send_seq('{8'h90, 8'h3C, 8'h40});
    tick(); tick(); tick();
    chk("t2a_trig", 32'(trig), 32'd0);
    chk("t2a_len",  32'(delay_length), 32'd367);
    chk("t2a_vel",  32'(velocity), 32'(c_v64));
    chk("t2a_note", 32'(note), 32'd60);
    send_seq('{8'h45, 8'h7F});
    chk("t2_hold_stable", 32'(delay_length), 32'd367);
    wait_trig("t2_end1", 1'b1);
    measure(1'b1, n);
    chk("t2_gap_ok", 32'(n >= int'(c_gap)), 32'd1);
    chk("t2b_trig", 32'(trig), 32'd0);
    chk("t2b_len",  32'(delay_length), 32'd218);
    chk("t2b_vel",  32'(velocity), 32'(c_v127));
    chk("t2b_note", 32'(note), 32'd69);
    measure(1'b0, n);
    chk("t2b_hold_len", 32'(n), 32'(c_hold));
    wait_idle("t2");
    n_exp += 2;
    chk("t2_count", 32'(n_fall), 32'(n_exp));

    // filtering: wrong channel, note-off, out of range, other status, sysex status
    send_seq('{8'h91, 8'h45, 8'h64, 8'h90, 8'h3C, 8'h00, 8'h10, 8'h64, 8'h6D, 8'h64,
               8'hB0, 8'h45, 8'h64, 8'h90, 8'hF0, 8'h45, 8'h64});
    repeat (20) tick();
    chk("t3_count", 32'(n_fall), 32'(n_exp));
    chk("t3_trig",  32'(trig), 32'd1);
    chk("t3_len",   32'(delay_length), 32'd218);
    chk("t3_busy",  32'(busy), 32'd0);

    // real-time bytes interleaved with a valid note
    send_seq('{8'h90, 8'hF8, 8'h3C, 8'hF8, 8'h50});
    tick(); tick(); tick();
    chk("t3b_trig", 32'(trig), 32'd0);
    chk("t3b_len",  32'(delay_length), 32'd367);
    chk("t3b_vel",  32'(velocity), 32'(c_v80));
    chk("t3b_note", 32'(note), 32'd60);
    wait_trig("t3b_end", 1'b1);
    wait_idle("t3b");
    n_exp += 1;

    // overwrite: three notes in one HOLD, range boundaries 21 and 108
    send_seq('{8'h90, 8'h15, 8'h7F, 8'h3C, 8'h7F, 8'h6C, 8'h7F});
    chk("t4a_trig", 32'(trig), 32'd0);
    chk("t4a_len",  32'(delay_length), 32'd3491);
    chk("t4a_note", 32'(note), 32'd21);
    chk("t4a_vel",  32'(velocity), 32'(c_v127));
    wait_trig("t4_end1", 1'b1);
    measure(1'b1, n);
    chk("t4_gap_ok", 32'(n >= int'(c_gap)), 32'd1);
    chk("t4b_trig", 32'(trig), 32'd0);
    chk("t4b_len",  32'(delay_length), 32'd23);
    chk("t4b_note", 32'(note), 32'd108);
    wait_trig("t4_end2", 1'b1);
    wait_idle("t4");
    repeat (20) tick();
    n_exp += 2;
    chk("t4_count", 32'(n_fall), 32'(n_exp));

    // reset mid-HOLD with a note pending
    send_seq('{8'h90, 8'h3C, 8'h40, 8'h45, 8'h7F});
    tick(); tick();
    chk("t5_trig_lo", 32'(trig), 32'd0);
    reset_n = 1'b0;
    tick();
    chk("t5_trig", 32'(trig), 32'd1);
    chk("t5_vel",  32'(velocity), 32'd0);
    chk("t5_len",  32'(delay_length), 32'd0);
    chk("t5_note", 32'(note), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    repeat (40) tick();
    n_exp += 1;
    chk("t5_count",     32'(n_fall), 32'(n_exp));
    chk("t5_trig_idle", 32'(trig), 32'd1);
    chk("t5_len_after", 32'(delay_length), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
